// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT constants, sample type, bank states
// and the bit-reversal helper.
package fft_bitrev_reorder_pkg;

  localparam int FFT_LOG2N = 3;
  localparam int FFT_W     = 16;

  typedef struct packed {
    logic signed [FFT_W-1:0] R;
    logic signed [FFT_W-1:0] I;
  } cplx_t;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  // Reverse the low 'bits' bits of k.
  function automatic logic [15:0] bitrev(
    input logic [15:0] k,
    input int unsigned bits
  );
    logic [15:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      if (j < bits) r[j] = k[4'(bits - 1 - j)];
    end
    return r;
  endfunction

  function automatic logic writable(
    input bank_state_t s
  );
    return (s == BANK_EMPTY) ||
           (s == BANK_FILLING);
  endfunction

  function automatic logic readable(
    input bank_state_t s
  );
    return (s == BANK_FULL) ||
           (s == BANK_DRAINING);
  endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// One ping-pong bank: N x 2W storage,
// synchronous write, asynchronous read.
module fft_bank_ram #(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [1 << AW];

  // Sample storage; contents are don't-care
  // until the bank state says otherwise.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order ping-pong reorder.
// FFT_REORDER_FRAME_CNT_EN adds the frame_cnt port.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N,
  parameter int W     = FFT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_R,
  input  logic signed [W-1:0] in_I,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_R,
  output logic signed [W-1:0] out_I,
  output logic                out_last
`ifdef FFT_REORDER_FRAME_CNT_EN
  ,
  output logic [15:0]         frame_cnt
`endif
);

  localparam logic [LOG2N-1:0] LAST = '1;

  bank_state_t st_q [2];
  bank_state_t st_d [2];

  logic             wbank_q;
  logic             rbank_q;
  logic [LOG2N-1:0] wcnt_q;
  logic [LOG2N-1:0] rptr_q;
  logic [LOG2N-1:0] waddr;
  logic [2*W-1:0]   rdata [2];
  logic [2*W-1:0]   rd_sel;
  logic             wr_en;
  logic             rd_ok;
  logic             load;

  assign in_ready = writable(st_q[wbank_q]);
  assign wr_en    = in_valid && in_ready;
  assign rd_ok    = readable(st_q[rbank_q]);
  assign load     = (!out_valid || out_ready)
                    && rd_ok;

  assign waddr = LOG2N'(
    bitrev(16'(wcnt_q), LOG2N));
  assign rd_sel = rdata[rbank_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_bank_ram #(
      .AW (LOG2N),
      .DW (2 * W)
    ) u_ram (
      .clk   (clk),
      .we    (wr_en && (wbank_q == 1'(b))),
      .waddr (waddr),
      .wdata ({in_R, in_I}),
      .raddr (rptr_q),
      .rdata (rdata[b])
    );
  end

  // Bank lifecycle: a bank is only ever written
  // or read in a given cycle, never both.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      st_d[b] = st_q[b];
      unique case (1'b1)
        (wr_en && wbank_q == 1'(b)):
          st_d[b] = (wcnt_q == LAST) ?
                    BANK_FULL : BANK_FILLING;
        (load && rbank_q == 1'(b)):
          st_d[b] = (rptr_q == LAST) ?
                    BANK_EMPTY : BANK_DRAINING;
        default: ;
      endcase
    end
  end

  // Bank state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q[0] <= BANK_EMPTY;
      st_q[1] <= BANK_EMPTY;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
    end
  end

  // Write count and read pointer; each bank
  // select flips when its side finishes a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
      rptr_q  <= '0;
      rbank_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wcnt_q <= wcnt_q + 1'b1;
        if (wcnt_q == LAST)
          wbank_q <= ~wbank_q;
      end
      if (load) begin
        rptr_q <= rptr_q + 1'b1;
        if (rptr_q == LAST)
          rbank_q <= ~rbank_q;
      end
    end
  end

  // Output register: refills whenever it is
  // free or being consumed; data holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_R     <= '0;
      out_I     <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_R     <= $signed(rd_sel[2*W-1:W]);
      out_I     <= $signed(rd_sel[W-1:0]);
      out_last  <= (rptr_q == LAST);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FFT_REORDER_FRAME_CNT_EN
  // Counts frames as their last sample is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (load && rptr_q == LAST) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: directed steps
// plus random traffic against a frame model.
module tb_fft_bitrev_reorder;
  import fft_bitrev_reorder_pkg::*;

  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;
  localparam int W     = 16;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] i;
    logic         last;
  } exp_t;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_R;
  logic signed [W-1:0] in_I;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_R;
  logic signed [W-1:0] out_I;
  logic                out_last;
`ifdef FFT_REORDER_FRAME_CNT_EN
  logic [15:0]         frame_cnt;
`endif

  fft_bitrev_reorder #(
    .LOG2N (LOG2N),
    .W     (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_R      (in_R),
    .in_I      (in_I),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_R     (out_R),
    .out_I     (out_I),
    .out_last  (out_last)
`ifdef FFT_REORDER_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int fcnt  = 0;
  logic popped;
  logic acc;

  exp_t         exp_q [$];
  cplx_t        frm   [$];
  logic [W-1:0] obs_r [$];

  int seq [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

  function automatic int brev(input int k);
    int r;
    int v;
    r = 0;
    v = k;
    for (int j = 0; j < LOG2N; j++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, observe #1
  // later, update the model, advance a cycle.
  task automatic cyc(
    input logic         iv,
    input logic [W-1:0] r,
    input logic [W-1:0] i,
    input logic         ordy
  );
    exp_t  e;
    cplx_t s;
    in_valid  = iv;
    in_R      = r;
    in_I      = i;
    out_ready = ordy;
    #1;
    popped = out_valid && out_ready;
    acc    = in_valid && in_ready;
    if (popped) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_R", 64'($unsigned(out_R)), 64'(e.r));
        chk("out_I", 64'($unsigned(out_I)), 64'(e.i));
        chk("out_last", 64'(out_last), 64'(e.last));
        obs_r.push_back($unsigned(out_R));
        if (e.last) fcnt++;
      end
    end
    if (acc) begin
      s.R = r;
      s.I = i;
      frm.push_back(s);
      if (frm.size() == N) begin
        for (int n = 0; n < N; n++) begin
          e.r    = frm[brev(n)].R;
          e.i    = frm[brev(n)].I;
          e.last = (n == N - 1);
          exp_q.push_back(e);
        end
        frm.delete();
      end
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      cyc(1'b0, '0, '0, 1'b1);
      guard++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int nacc;
    int first;
    int lastp;
    int npop;
    int guard;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_R      = '0;
    in_I      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_R", 64'($unsigned(out_R)), 64'd0);
    chk("rst_out_I", 64'($unsigned(out_I)), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef FFT_REORDER_FRAME_CNT_EN
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
    rst = 1'b0;

    // Single frame R=k, I=-k; latency check.
    for (int k = 0; k < N; k++)
      cyc(1'b1, W'(k), W'(-k), 1'b0);
    chk("lat_before", 64'(out_valid), 64'd0);
    cyc(1'b0, '0, '0, 1'b0);
    chk("lat_after", 64'(out_valid), 64'd1);
    chk("lat_idx0", 64'($unsigned(out_R)), 64'd0);
    obs_r.delete();
    drain("frame1_drain");
    for (int n = 0; n < N; n++)
      chk("frame1_seq",
          64'(obs_r[n]), 64'(seq[n]));
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_hold", 64'($unsigned(out_R)), 64'd7);

    // Ramp of 8 frames at full rate.
    sent  = 0;
    first = -1;
    lastp = -1;
    npop  = 0;
    guard = 0;
    while ((sent < 8 * N || exp_q.size() != 0)
           && guard < 300) begin
      cyc(sent < 8 * N, W'(sent), ~W'(sent), 1'b1);
      if (acc) sent++;
      if (popped) begin
        if (first < 0) first = cyc_n;
        lastp = cyc_n;
        npop++;
      end
      guard++;
    end
    chk("ramp_pops", 64'(npop), 64'(8 * N));
    chk("ramp_span", 64'(lastp - first + 1),
        64'(8 * N));

    // Downstream stall with input pressure.
    nacc  = 0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      cyc(1'b1, W'($urandom), W'($urandom), 1'b0);
      if (acc) nacc++;
      guard++;
    end
    repeat (20) begin
      cyc(1'b1, W'($urandom), W'($urandom), 1'b0);
      if (acc) nacc++;
    end
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_accepts", 64'(nacc), 64'(2 * N));
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_hold_R", 64'($unsigned(out_R)),
        64'(exp_q[0].r));
    chk("stall_last", 64'(out_last), 64'd0);
    drain("stall_drain");

    // Random gaps on both sides, 100 frames.
    sent  = 0;
    guard = 0;
    while ((sent < 100 * N || exp_q.size() != 0)
           && guard < 6000) begin
      cyc((sent < 100 * N) && ($urandom % 4 != 0),
          W'($urandom), W'($urandom),
          ($urandom % 3 != 0));
      if (acc) sent++;
      guard++;
    end
    chk("rand_sent", 64'(sent), 64'(100 * N));
    chk("rand_left", 64'(exp_q.size()), 64'd0);
`ifdef FFT_REORDER_FRAME_CNT_EN
    chk("frame_cnt", 64'(frame_cnt),
        64'(fcnt % 65536));
`endif

    // Reset mid-frame while a frame drains.
    for (int k = 0; k < N + 5; k++)
      cyc(1'b1, W'($urandom), W'($urandom), 1'b1);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_R", 64'($unsigned(out_R)), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    frm.delete();
    fcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) cyc(1'b0, '0, '0, 1'b1);
    for (int k = 0; k < N; k++)
      cyc(1'b1, W'($urandom), W'($urandom), 1'b1);
    drain("post_rst_drain");
    chk("post_rst_valid", 64'(out_valid), 64'd0);
`ifdef FFT_REORDER_FRAME_CNT_EN
    chk("post_rst_fcnt", 64'(frame_cnt), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
